// File: rtl/conv_para_sequencer_pkg.sv
// Shared CNN parameters, FSM state encoding and op codes for the convolution sequencer.
// Build option: CONV_SEQ_WATCHDOG_EN enables the DRAIN watchdog (limit WD_LIMIT cycles).
package conv_para_sequencer_pkg;

    localparam int unsigned CNN_DATA_WIDTH        = 16;
    localparam int unsigned CNN_PARA_X            = 3;
    localparam int unsigned CNN_PARA_Y            = 3;
    localparam int unsigned CNN_KERNEL_SIZE_WIDTH = 4;

    localparam int unsigned WD_LIMIT     = 64;
    localparam int unsigned WD_CNT_WIDTH = $clog2(WD_LIMIT);

    localparam logic OP_CONV = 1'b0;
    localparam logic OP_FC   = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_HOLD  = 3'd4,
        S_CLEAR = 3'd5
    } seq_state_e;

endpackage

// File: rtl/conv_para_sequencer_step_counter.sv
// Fetch step counter: loads the job length N, counts 0..N-1 on advance and saturates at N-1.
module conv_step_counter #(
    parameter int unsigned STEP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [STEP_WIDTH-1:0] n,
    input  logic                  advance,
    output logic [STEP_WIDTH-1:0] step,
    output logic                  last
);

    logic [STEP_WIDTH-1:0] step_q, step_d;
    logic [STEP_WIDTH-1:0] n_q, n_d;

    always_comb begin
        step_d = step_q;
        n_d    = n_q;
        if (load) begin
            step_d = '0;
            n_d    = n;
        end else if (advance && !last) begin
            step_d = step_q + STEP_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q <= '0;
            n_q    <= '0;
        end else begin
            step_q <= step_d;
            n_q    <= n_d;
        end
    end

    assign step = step_q;
    // n_q is 0 only before the first load, where step (0) never matches all-ones
    assign last = (step_q == (n_q - STEP_WIDTH'(1)));

endmodule

// File: rtl/conv_para_sequencer.sv
// Job sequencer for the PARA_X x PARA_Y conv/fc engine: fetches N operand steps, feeds them,
// waits for the result and holds it for downstream. Build option: CONV_SEQ_WATCHDOG_EN.
module conv_para_sequencer
    import conv_para_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = CNN_DATA_WIDTH,
    parameter int unsigned PARA_X            = CNN_PARA_X,
    parameter int unsigned PARA_Y            = CNN_PARA_Y,
    parameter int unsigned KERNEL_SIZE_WIDTH = CNN_KERNEL_SIZE_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  op_type,
    input  logic [KERNEL_SIZE_WIDTH-1:0]          kernel_size,
    output logic                                  busy,
    output logic                                  err,
    output logic                                  src_rd_en,
    output logic [2*KERNEL_SIZE_WIDTH-1:0]        src_rd_step,
    input  logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]   src_input,
    input  logic [DATA_WIDTH-1:0]                 src_weight,
    output logic                                  eng_rst,
    output logic                                  eng_op_type,
    output logic [KERNEL_SIZE_WIDTH-1:0]          eng_kernel_size,
    output logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]   eng_input_data,
    output logic [DATA_WIDTH-1:0]                 eng_weight,
    input  logic                                  eng_result_ready,
    input  logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]   eng_result_buffer,
    output logic                                  out_valid,
    output logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]   out_data,
    input  logic                                  out_ready
);

    localparam int unsigned KW = KERNEL_SIZE_WIDTH;
    localparam int unsigned SW = 2 * KERNEL_SIZE_WIDTH;
    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned PW = PARA_X * PARA_Y * DATA_WIDTH;

    seq_state_e    state_q, state_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic          src_rd_en_q, src_rd_en_d;
    logic          eng_rst_q, eng_rst_d;
    logic          eng_op_type_q, eng_op_type_d;
    logic [KW-1:0] eng_kernel_size_q, eng_kernel_size_d;
    logic [PW-1:0] data_q, data_d;
    logic [DW-1:0] weight_q, weight_d;
    logic          out_valid_q, out_valid_d;
    logic [PW-1:0] out_data_q, out_data_d;

    logic          cnt_load_c;
    logic [SW-1:0] n_c;
    logic [SW-1:0] step_c;
    logic          step_last_c;
    logic          legal_c;

`ifdef CONV_SEQ_WATCHDOG_EN
    logic [WD_CNT_WIDTH-1:0] wd_cnt_q, wd_cnt_d;
`endif

    // Job length and legality of the requested kernel size
    always_comb begin
        if (op_type == OP_FC) begin
            n_c     = SW'(kernel_size);
            legal_c = (kernel_size >= KW'(1));
        end else begin
            n_c     = SW'(kernel_size) * SW'(kernel_size);
            legal_c = (kernel_size >= KW'(2));
        end
    end

    conv_step_counter #(
        .STEP_WIDTH (SW)
    ) u_step_counter (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load_c),
        .n       (n_c),
        .advance (src_rd_en_q),
        .step    (step_c),
        .last    (step_last_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d           = state_q;
        err_d             = 1'b0;
        src_rd_en_d       = 1'b0;
        eng_rst_d         = eng_rst_q;
        eng_op_type_d     = eng_op_type_q;
        eng_kernel_size_d = eng_kernel_size_q;
        data_d            = data_q;
        weight_d          = weight_q;
        out_valid_d       = out_valid_q;
        out_data_d        = out_data_q;
        cnt_load_c        = 1'b0;
`ifdef CONV_SEQ_WATCHDOG_EN
        wd_cnt_d          = '0;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (legal_c) begin
                        state_d           = S_FETCH;
                        cnt_load_c        = 1'b1;
                        src_rd_en_d       = 1'b1;
                        eng_rst_d         = 1'b1;
                        eng_op_type_d     = op_type;
                        eng_kernel_size_d = kernel_size;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                state_d     = S_FEED;
                src_rd_en_d = src_rd_en_q && !step_last_c;
            end
            S_FEED: begin
                data_d      = src_input;
                weight_d    = src_weight;
                src_rd_en_d = src_rd_en_q && !step_last_c;
                // The final feed cycle is the only one with no fetch outstanding
                if (!src_rd_en_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (eng_result_ready) begin
                    state_d     = S_HOLD;
                    out_valid_d = 1'b1;
                    out_data_d  = eng_result_buffer;
                end
`ifdef CONV_SEQ_WATCHDOG_EN
                else if (wd_cnt_q == WD_CNT_WIDTH'(WD_LIMIT - 1)) begin
                    state_d   = S_CLEAR;
                    err_d     = 1'b1;
                    eng_rst_d = 1'b0;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_CNT_WIDTH'(1);
                end
`endif
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d     = S_CLEAR;
                    out_valid_d = 1'b0;
                    eng_rst_d   = 1'b0;
                end
            end
            S_CLEAR: begin
                state_d   = S_IDLE;
                eng_rst_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= S_IDLE;
            busy_q            <= 1'b0;
            err_q             <= 1'b0;
            src_rd_en_q       <= 1'b0;
            eng_rst_q         <= 1'b0;
            eng_op_type_q     <= 1'b0;
            eng_kernel_size_q <= '0;
            data_q            <= '0;
            weight_q          <= '0;
            out_valid_q       <= 1'b0;
            out_data_q        <= '0;
`ifdef CONV_SEQ_WATCHDOG_EN
            wd_cnt_q          <= '0;
`endif
        end else begin
            state_q           <= state_d;
            busy_q            <= busy_d;
            err_q             <= err_d;
            src_rd_en_q       <= src_rd_en_d;
            eng_rst_q         <= eng_rst_d;
            eng_op_type_q     <= eng_op_type_d;
            eng_kernel_size_q <= eng_kernel_size_d;
            data_q            <= data_d;
            weight_q          <= weight_d;
            out_valid_q       <= out_valid_d;
            out_data_q        <= out_data_d;
`ifdef CONV_SEQ_WATCHDOG_EN
            wd_cnt_q          <= wd_cnt_d;
`endif
        end
    end

    assign busy            = busy_q;
    assign err             = err_q;
    assign src_rd_en       = src_rd_en_q;
    assign src_rd_step     = step_c;
    assign eng_rst         = eng_rst_q;
    assign eng_op_type     = eng_op_type_q;
    assign eng_kernel_size = eng_kernel_size_q;
    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;

    // Source data arrives one cycle after the fetch, so feed cycles pass it straight through;
    // outside FEED the engine sees the last word fed (zero after reset).
    assign eng_input_data = (state_q == S_FEED) ? src_input  : data_q;
    assign eng_weight     = (state_q == S_FEED) ? src_weight : weight_q;

endmodule

// File: tb/tb_conv_para_sequencer.sv
// Self-checking bench for conv_para_sequencer: directed scenarios plus randomized jobs
// checked cycle by cycle against a job-timeline model. Build option: CONV_SEQ_WATCHDOG_EN.
module tb_conv_para_sequencer;

    localparam int DW = 16;
    localparam int KW = 4;
    localparam int SW = 2 * KW;
    localparam int LANES = 9;
    localparam int PW = LANES * DW;
    localparam int WD_CYCLES = 64;

    logic          clk;
    logic          rst;
    logic          start;
    logic          op_type;
    logic [KW-1:0] kernel_size;
    logic          busy;
    logic          err;
    logic          src_rd_en;
    logic [SW-1:0] src_rd_step;
    logic [PW-1:0] src_input;
    logic [DW-1:0] src_weight;
    logic          eng_rst;
    logic          eng_op_type;
    logic [KW-1:0] eng_kernel_size;
    logic [PW-1:0] eng_input_data;
    logic [DW-1:0] eng_weight;
    logic          eng_result_ready;
    logic [PW-1:0] eng_result_buffer;
    logic          out_valid;
    logic [PW-1:0] out_data;
    logic          out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [PW-1:0] mem_in [0:224];
    logic [DW-1:0] mem_w  [0:224];

    conv_para_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .op_type           (op_type),
        .kernel_size       (kernel_size),
        .busy              (busy),
        .err               (err),
        .src_rd_en         (src_rd_en),
        .src_rd_step       (src_rd_step),
        .src_input         (src_input),
        .src_weight        (src_weight),
        .eng_rst           (eng_rst),
        .eng_op_type       (eng_op_type),
        .eng_kernel_size   (eng_kernel_size),
        .eng_input_data    (eng_input_data),
        .eng_weight        (eng_weight),
        .eng_result_ready  (eng_result_ready),
        .eng_result_buffer (eng_result_buffer),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_ready         (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    function automatic real fp16_to_real(input logic [15:0] h);
        real m;
        int  e;
        if (h[14:10] == 5'd0) return 0.0;
        m = 1.0 + real'(h[9:0]) / 1024.0;
        e = int'(h[14:10]) - 15;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return m;
    endfunction

    function automatic logic [15:0] real_to_fp16(input real x);
        int         e;
        real        m;
        logic [4:0] ef;
        logic [9:0] mf;
        if (x <= 0.0) return 16'h0000;
        e = 0;
        m = x;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        ef = 5'(e + 15);
        mf = 10'($rtoi((m - 1.0) * 1024.0));
        return {1'b0, ef, mf};
    endfunction

    // Engine reference: each lane accumulates input*weight over the job's N steps
    function automatic logic [PW-1:0] engine_golden(input int n);
        logic [PW-1:0] r;
        real           acc;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            acc = 0.0;
            for (int i = 0; i < n; i++)
                acc = acc + fp16_to_real(mem_in[i][l*DW +: DW]) * fp16_to_real(mem_w[i]);
            r[l*DW +: DW] = real_to_fp16(acc);
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] rand_word();
        return PW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            mem_in[i] = rand_word();
            mem_w[i]  = DW'($urandom());
        end
    endtask

    // One job, checked cycle by cycle. drain_dly<0 means the engine never answers.
    task automatic run_job(input logic op, input logic [KW-1:0] ks, input int drain_dly,
                           input int stall, input logic [PW-1:0] res, input bit poke,
                           input int rst_at);
        int            n;
        bit            pend;
        logic [SW-1:0] pstep;
        bit            exp_en;
        int            exp_step;
        n = (op == 1'b1) ? int'(ks) : int'(ks) * int'(ks);

        @(posedge clk); #1;
        start = 1'b1; op_type = op; kernel_size = ks; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; op_type = ~op; kernel_size = KW'($urandom());
        @(negedge clk);
        n_tests++;
        if ({busy, err, src_rd_en, eng_rst, out_valid} !== 5'b10110) begin
            n_fail++;
            $display("FAIL fetch_flags got=%b exp=10110", {busy, err, src_rd_en, eng_rst, out_valid});
        end
        n_tests++;
        if ({eng_op_type, eng_kernel_size, src_rd_step} !== {op, ks, 8'd0}) begin
            n_fail++;
            $display("FAIL fetch_cfg got op=%0b ks=%0d step=%0d exp op=%0b ks=%0d step=0",
                     eng_op_type, eng_kernel_size, src_rd_step, op, ks);
        end
        pend = src_rd_en; pstep = src_rd_step;

        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (pend) begin
                src_input = mem_in[pstep]; src_weight = mem_w[pstep];
            end else begin
                src_input = rand_word(); src_weight = DW'($urandom());
            end
            @(negedge clk);
            exp_en   = (i + 1 < n);
            exp_step = exp_en ? i + 1 : n - 1;
            n_tests++;
            if ({eng_input_data, eng_weight} !== {mem_in[i], mem_w[i]}) begin
                n_fail++;
                $display("FAIL feed_data i=%0d got=%h/%h exp=%h/%h", i, eng_input_data, eng_weight,
                         mem_in[i], mem_w[i]);
            end
            n_tests++;
            if ({busy, err, src_rd_en, eng_rst, out_valid} !== {1'b1, 1'b0, exp_en, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL feed_flags i=%0d got=%b exp=%b", i, {busy, err, src_rd_en, eng_rst, out_valid},
                         {1'b1, 1'b0, exp_en, 1'b1, 1'b0});
            end
            n_tests++;
            if (src_rd_step !== SW'(exp_step)) begin
                n_fail++;
                $display("FAIL feed_step i=%0d got=%0d exp=%0d", i, src_rd_step, exp_step);
            end
            pend = src_rd_en; pstep = src_rd_step;
            if (i == rst_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                n_tests++;
                if ({busy, err, src_rd_en, eng_rst, out_valid} !== 5'b00000) begin
                    n_fail++;
                    $display("FAIL rst_mid_feed got=%b exp=00000", {busy, err, src_rd_en, eng_rst, out_valid});
                end
                return;
            end
        end

`ifdef CONV_SEQ_WATCHDOG_EN
        if (drain_dly < 0) begin
            for (int d = 0; d < WD_CYCLES; d++) begin
                @(posedge clk); #1;
                eng_result_ready = 1'b0; eng_result_buffer = rand_word(); out_ready = 1'b1;
                @(negedge clk);
                n_tests++;
                if ({busy, err, eng_rst, out_valid} !== 4'b1010) begin
                    n_fail++;
                    $display("FAIL wd_drain d=%0d got=%b exp=1010", d, {busy, err, eng_rst, out_valid});
                end
            end
            @(posedge clk); #1;
            @(negedge clk);
            n_tests++;
            if ({busy, err, eng_rst, out_valid} !== 4'b1100) begin
                n_fail++;
                $display("FAIL wd_expire got=%b exp=1100", {busy, err, eng_rst, out_valid});
            end
            @(posedge clk); #1;
            @(negedge clk);
            n_tests++;
            if ({busy, err, out_valid} !== 3'b000) begin
                n_fail++;
                $display("FAIL wd_idle got=%b exp=000", {busy, err, out_valid});
            end
            return;
        end
`endif

        for (int d = 0; d <= drain_dly; d++) begin
            @(posedge clk); #1;
            src_input = rand_word(); src_weight = DW'($urandom());
            eng_result_ready  = (d == drain_dly);
            eng_result_buffer = (d == drain_dly) ? res : rand_word();
            out_ready = (d == drain_dly);
            @(negedge clk);
            n_tests++;
            if ({busy, err, src_rd_en, eng_rst, out_valid} !== 5'b10010) begin
                n_fail++;
                $display("FAIL drain_flags d=%0d got=%b exp=10010", d, {busy, err, src_rd_en, eng_rst, out_valid});
            end
            n_tests++;
            if ({eng_input_data, eng_weight} !== {mem_in[n-1], mem_w[n-1]}) begin
                n_fail++;
                $display("FAIL drain_hold d=%0d got=%h exp=%h", d, eng_input_data, mem_in[n-1]);
            end
        end

        for (int h = 0; h <= stall; h++) begin
            @(posedge clk); #1;
            eng_result_ready = 1'b0; eng_result_buffer = rand_word();
            out_ready = (h == stall);
            start = poke && (h <= 1);
            op_type = 1'b0;
            kernel_size = (h == 0) ? KW'(0) : KW'(2);
            @(negedge clk);
            n_tests++;
            if ({busy, err, eng_rst, out_valid} !== 4'b1011) begin
                n_fail++;
                $display("FAIL hold_flags h=%0d got=%b exp=1011", h, {busy, err, eng_rst, out_valid});
            end
            n_tests++;
            if (out_data !== res) begin
                n_fail++;
                $display("FAIL hold_data h=%0d got=%h exp=%h", h, out_data, res);
            end
        end

        @(posedge clk); #1;
        start = 1'b0; out_ready = 1'(($urandom() & 1));
        @(negedge clk);
        n_tests++;
        if ({busy, err, eng_rst, out_valid, eng_op_type, eng_kernel_size} !== {4'b1000, op, ks}) begin
            n_fail++;
            $display("FAIL clear got=%b exp=%b", {busy, err, eng_rst, out_valid, eng_op_type, eng_kernel_size},
                     {4'b1000, op, ks});
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({busy, err, eng_rst, out_valid} !== 4'b0010) begin
            n_fail++;
            $display("FAIL idle_after got=%b exp=0010", {busy, err, eng_rst, out_valid});
        end
    endtask

    task automatic do_illegal(input logic op, input logic [KW-1:0] ks);
        @(posedge clk); #1;
        start = 1'b1; op_type = op; kernel_size = ks;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({busy, err, src_rd_en} !== 3'b010) begin
            n_fail++;
            $display("FAIL illegal_pulse op=%0b ks=%0d got=%b exp=010", op, ks, {busy, err, src_rd_en});
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if ({busy, err} !== 2'b00) begin
            n_fail++;
            $display("FAIL illegal_after op=%0b ks=%0d got=%b exp=00", op, ks, {busy, err});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; op_type = 1'b0; kernel_size = 4'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({busy, err, src_rd_en, src_rd_step, eng_rst, eng_op_type, eng_kernel_size} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%b exp=0", {busy, err, src_rd_en, src_rd_step, eng_rst,
                     eng_op_type, eng_kernel_size});
        end
        n_tests++;
        if ({eng_input_data, eng_weight, out_valid, out_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data got=%h/%h/%b/%h exp=0", eng_input_data, eng_weight, out_valid, out_data);
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_tests++;
            if ({busy, eng_rst} !== 2'b00) begin
                n_fail++;
                $display("FAIL post_reset got=%b exp=00", {busy, eng_rst});
            end
        end
    endtask

    task automatic test_conv_k3();
        logic [PW-1:0] ones;
        for (int l = 0; l < LANES; l++) ones[l*DW +: DW] = 16'h3c00;
        for (int i = 0; i < 9; i++) begin
            mem_in[i] = ones; mem_w[i] = 16'h3c00;
        end
        run_job(1'b0, 4'd3, 2, 0, {LANES{16'h4880}}, 1'b0, -1);
    endtask

    task automatic test_fc_k4();
        logic [15:0] l0 [0:3];
        logic [15:0] l1 [0:3];
        logic [15:0] ws [0:3];
        l0[0] = 16'h3c00; l0[1] = 16'h4000; l0[2] = 16'h4200; l0[3] = 16'h4400;
        l1[0] = 16'h4000; l1[1] = 16'h4200; l1[2] = 16'h3c00; l1[3] = 16'h4200;
        ws[0] = 16'h3c00; ws[1] = 16'h4000; ws[2] = 16'h4200; ws[3] = 16'h4400;
        for (int i = 0; i < 4; i++) begin
            mem_in[i] = '0;
            mem_in[i][15:0]  = l0[i];
            mem_in[i][31:16] = l1[i];
            mem_in[i][47:32] = (i == 0) ? 16'h4000 : 16'h0000;
            mem_w[i] = ws[i];
        end
        run_job(1'b1, 4'd4, 0, 0, engine_golden(4), 1'b0, -1);
        n_tests++;
        if (out_data[47:0] !== 48'h4000_4dc0_4f80) begin
            n_fail++;
            $display("FAIL fc_low_lanes got=%h exp=40004dc04f80", out_data[47:0]);
        end
    endtask

    task automatic test_illegal();
        do_illegal(1'b0, 4'd1);
        do_illegal(1'b0, 4'd0);
        do_illegal(1'b1, 4'd0);
    endtask

    task automatic test_rst_mid_feed();
        fill_random(9);
        run_job(1'b0, 4'd3, 0, 0, '0, 1'b0, 5);
        fill_random(9);
        run_job(1'b0, 4'd3, 1, 0, engine_golden(9), 1'b0, -1);
    endtask

    task automatic test_hold_stall();
        fill_random(4);
        run_job(1'b1, 4'd4, 0, 10, rand_word(), 1'b1, -1);
    endtask

    task automatic test_random_jobs();
        logic          op;
        logic [KW-1:0] ks;
        for (int j = 0; j < 20; j++) begin
            op = 1'(($urandom() & 1));
            ks = op ? KW'($urandom_range(1, 15)) : KW'($urandom_range(2, 6));
            fill_random(op ? int'(ks) : int'(ks) * int'(ks));
            if ($urandom_range(0, 3) == 0)
                do_illegal(op, op ? KW'(0) : KW'($urandom_range(0, 1)));
            run_job(op, ks, $urandom_range(0, 5), $urandom_range(0, 3), rand_word(),
                    1'(($urandom() & 1)), -1);
        end
    endtask

`ifdef CONV_SEQ_WATCHDOG_EN
    task automatic test_watchdog();
        fill_random(4);
        run_job(1'b0, 4'd2, -1, 0, '0, 1'b0, -1);
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; op_type = 1'b0; kernel_size = '0;
        src_input = '0; src_weight = '0;
        eng_result_ready = 1'b0; eng_result_buffer = '0; out_ready = 1'b0;
        test_reset();
        test_conv_k3();
        test_fc_k4();
        test_illegal();
        test_rst_mid_feed();
        test_hold_stall();
        test_random_jobs();
`ifdef CONV_SEQ_WATCHDOG_EN
        test_watchdog();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
